peri_tl_host: RTL



---
 rtl/peri_tl_host_pkg.sv | 6 +
 rtl/tlul_pkg.sv | 36 +++
 rtl/tlul_cmd_intg_gen.sv | 20 ++
 rtl/peri_tl_host.sv | 111 +++++++++++
 4 files changed

// File: rtl/peri_tl_host_pkg.sv
// peri_tl_host_pkg: FSM states and fixed A-channel constants of peri_tl_host
package peri_tl_host_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RSP, DRAIN} peri_tl_host_state_e;
  localparam int AccessSize = 2;
  localparam logic [3:0] FullMask = 4'hF;
endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TL-UL types and opcodes used by the peripheral host
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;
  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// tlul_cmd_intg_gen: 7-bit interleaved parity over the A command and data for a_user
// opcode/addr/mask/data: A-channel fields; user: cmd_intg and data_intg
module tlul_cmd_intg_gen
  import tlul_pkg::*;
(
  input  logic [2:0]  opcode,
  input  logic [31:0] addr,
  input  logic [3:0]  mask,
  input  logic [31:0] data,
  output tl_a_user_t  user
);
  // bit i of the 39-bit payload lands in parity bit i mod 7
  function automatic logic [6:0] fold(input logic [38:0] v);
    logic [41:0] p;
    p = {3'b000, v};
    return p[6:0] ^ p[13:7] ^ p[20:14] ^ p[27:21] ^ p[34:28] ^ p[41:35];
  endfunction
  assign user.cmd_intg  = fold({opcode, mask, addr});
  assign user.data_intg = fold({7'b0, data});
endmodule

// File: rtl/peri_tl_host.sv
// peri_tl_host: single-outstanding TL-UL initiator behind a req/gnt/rvalid register port
// clk_i/rst_i: clock, sync active-high reset; req_i/we_i/addr_i/wdata_i/be_i/gnt_o: request;
// rvalid_o/rdata_o/err_o: completion; busy_o: not idle; tl_o/tl_i: TL-UL host side
module peri_tl_host
  import tlul_pkg::*;
  import peri_tl_host_pkg::*;
#(
  parameter int SourceId      = 0,
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);
  localparam int CW = $clog2(TimeoutCycles + 1);
  localparam logic [7:0] Src = 8'(SourceId);
  peri_tl_host_state_e state_q, state_d;
  logic we_q;
  logic [31:2] addr_q;
  logic [31:0] wdata_q, data;
  logic [3:0] be_q, mask;
  logic [CW-1:0] cnt_q;
  logic bad, tmo, rsp_err;
  tl_a_op_e op;
  tl_a_user_t user;
  assign gnt_o = req_i & (state_q == IDLE) & ~rst_i;
  // misaligned or empty-write requests complete with an error and never reach the bus
  assign bad = (addr_i[1:0] != 2'b00) | (we_i & (be_i == 4'h0));
  assign tmo = cnt_q == CW'(TimeoutCycles - 1);
  assign busy_o = state_q != IDLE;
  assign op = !we_q ? Get : (be_q == FullMask) ? PutFullData : PutPartialData;
  assign mask = we_q ? be_q : FullMask;
  assign data = we_q ? wdata_q : '0;
  assign rsp_err = tl_i.d_error | (tl_i.d_source != Src) |
                   (tl_i.d_opcode != (we_q ? AccessAck : AccessAckData));
  tlul_cmd_intg_gen u_intg (
    .opcode(op),
    .addr  ({addr_q, 2'b00}),
    .mask  (mask),
    .data  (data),
    .user  (user)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (gnt_o & ~bad) ? REQ : IDLE;
      REQ:     state_d = tl_i.a_ready ? RSP : REQ;
      RSP:     state_d = tl_i.d_valid ? IDLE : tmo ? DRAIN : RSP;
      DRAIN:   state_d = tl_i.d_valid ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tl_o = '0;
    tl_o.a_valid = state_q == REQ;
    tl_o.a_opcode = op;
    tl_o.a_size = 2'(AccessSize);
    tl_o.a_source = Src;
    tl_o.a_address = {addr_q, 2'b00};
    tl_o.a_mask = mask;
    tl_o.a_data = data;
    tl_o.a_user = user;
    tl_o.d_ready = ~rst_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rvalid_o <= 1'b0;
      err_o <= 1'b0;
      rdata_o <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else begin
      state_q <= state_d;
      rvalid_o <= 1'b0;
      if (gnt_o) begin
        we_q <= we_i;
        addr_q <= addr_i[31:2];
        wdata_q <= wdata_i;
        be_q <= be_i;
      end
      if (state_q == REQ && tl_i.a_ready) cnt_q <= '0;
      else if (state_q == RSP && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (gnt_o & bad) begin
        rvalid_o <= 1'b1;
        err_o <= 1'b1;
        rdata_o <= '0;
      end
      // a response on the terminal-count cycle beats the timeout
      if (state_q == RSP && (tl_i.d_valid || tmo)) begin
        rvalid_o <= 1'b1;
        err_o <= ~tl_i.d_valid | rsp_err;
        rdata_o <= (tl_i.d_valid & ~we_q) ? tl_i.d_data : '0;
      end
    end
  end
endmodule
